// File: rtl/ctrl_pipe_regs.sv
// ctrl_pipe_regs: generic N-stage control-bundle pipeline for the MIPS core.
// Each stage has its own stall, flush, valid bit and keep mask. Non-monotone
// stall patterns set a sticky error. The block also counts cycles in which the
// last stage holds a bubble, saturating at the top of the counter range.
module ctrl_pipe_regs #(
  parameter int unsigned            NSTAGES   = 3,
  parameter int unsigned            CW        = 8,
  parameter logic [NSTAGES*CW-1:0]  KEEP_MASK = {(NSTAGES*CW){1'b1}},
  parameter int unsigned            CNTW      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CW-1:0]           ctrl_d,
  input  logic                    valid_d,
  input  logic [NSTAGES-1:0]      stall,
  input  logic [NSTAGES-1:0]      flush,
  output logic                    accept_d,
  output logic [NSTAGES*CW-1:0]   ctrl_q,
  output logic [NSTAGES-1:0]      valid_q,
  output logic                    stall_err,
  output logic [CNTW-1:0]         bubble_cnt
);

  logic [NSTAGES-1:0][CW-1:0] stg_ctrl_q, stg_ctrl_d, src_ctrl;
  logic [NSTAGES-1:0]         stg_vld_q, stg_vld_d, src_vld, up_hold;
  logic                       stall_bad;
  logic                       err_q, err_d;
  logic [CNTW-1:0]            cnt_q, cnt_d;

  // Work out what each stage would load: the decoder for stage 0, the previous
  // register otherwise. Also flag stages whose upstream register is holding.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    src_ctrl    = '0;
    src_vld     = '0;
    up_hold     = '0;
    src_ctrl[0] = ctrl_d;
    src_vld[0]  = valid_d;
    for (int k = 1; k < int'(NSTAGES); k++) begin
      src_ctrl[k] = stg_ctrl_q[k-1];
      src_vld[k]  = stg_vld_q[k-1];
      up_hold[k]  = stall[k-1] & ~flush[k-1];
    end
  end

  // Per-stage next state. Flush beats stall, and stall beats load. A stage whose
  // upstream neighbour is holding takes a bubble, so the held entry is never
  // duplicated.
  always_comb begin
    stg_ctrl_d = stg_ctrl_q;
    stg_vld_d  = stg_vld_q;
    for (int k = 0; k < int'(NSTAGES); k++) begin
      if (flush[k]) begin
        stg_ctrl_d[k] = '0;
        stg_vld_d[k]  = 1'b0;
      end else if (stall[k]) begin
        stg_ctrl_d[k] = stg_ctrl_q[k];
        stg_vld_d[k]  = stg_vld_q[k];
      end else if (up_hold[k]) begin
        stg_ctrl_d[k] = '0;
        stg_vld_d[k]  = 1'b0;
      end else begin
        stg_ctrl_d[k] = src_ctrl[k] & KEEP_MASK[k*CW +: CW];
        stg_vld_d[k]  = src_vld[k];
      end
    end
  end

  // Detect a stalled stage sitting behind an unstalled upstream stage. The loop
  // body never runs when there is only one stage, so the error stays clear.
  always_comb begin
    stall_bad = 1'b0;
    for (int k = 1; k < int'(NSTAGES); k++) begin
      if (stall[k] && !stall[k-1]) stall_bad = 1'b1;
    end
    err_d = err_q | stall_bad;
  end

  // Bubble counter: count each edge where the last stage is empty, and stop at
  // all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (!stg_vld_q[NSTAGES-1] && (cnt_q != {CNTW{1'b1}})) cnt_d = cnt_q + CNTW'(1);
  end

  // State registers. Reset is synchronous and overrides every other input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments, so every
    // stage samples its pre-edge source and the pipeline shifts by one place.
    if (reset) begin
      // NOTE: this is a handful of flops, not a memory array, so clearing all
      // of them on reset keeps every output free of X after the first reset edge.
      stg_ctrl_q <= '0;
      stg_vld_q  <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      stg_ctrl_q <= stg_ctrl_d;
      stg_vld_q  <= stg_vld_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign accept_d   = ~stall[0] & ~flush[0] & ~reset;
  assign ctrl_q     = stg_ctrl_q;
  assign valid_q    = stg_vld_q;
  assign stall_err  = err_q;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Directed testbench for ctrl_pipe_regs. All instances share one stimulus:
//   dut_a: default parameters
//   dut_b: stage-2 keep mask 8'h0F, 4-bit bubble counter
//   dut_c: a single stage
module tb_ctrl_pipe_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  ctrl_d;
  logic        valid_d;
  logic [2:0]  stall, flush;

  logic        a_acc, b_acc, c_acc;
  logic [23:0] a_ctrl, b_ctrl;
  logic [7:0]  c_ctrl;
  logic [2:0]  a_vld, b_vld;
  logic        c_vld;
  logic        a_err, b_err, c_err;
  logic [15:0] a_cnt, c_cnt;
  logic [3:0]  b_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_pipe_regs dut_a (
    .clk(clk), .reset(reset), .ctrl_d(ctrl_d), .valid_d(valid_d),
    .stall(stall), .flush(flush), .accept_d(a_acc), .ctrl_q(a_ctrl),
    .valid_q(a_vld), .stall_err(a_err), .bubble_cnt(a_cnt)
  );

  ctrl_pipe_regs #(.KEEP_MASK(24'h0FFFFF), .CNTW(4)) dut_b (
    .clk(clk), .reset(reset), .ctrl_d(ctrl_d), .valid_d(valid_d),
    .stall(stall), .flush(flush), .accept_d(b_acc), .ctrl_q(b_ctrl),
    .valid_q(b_vld), .stall_err(b_err), .bubble_cnt(b_cnt)
  );

  ctrl_pipe_regs #(.NSTAGES(1)) dut_c (
    .clk(clk), .reset(reset), .ctrl_d(ctrl_d), .valid_d(valid_d),
    .stall(stall[0]), .flush(flush[0]), .accept_d(c_acc), .ctrl_q(c_ctrl),
    .valid_q(c_vld), .stall_err(c_err), .bubble_cnt(c_cnt)
  );

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] c, input logic v,
                       input logic [2:0] s, input logic [2:0] f);
    ctrl_d  = c;
    valid_d = v;
    stall   = s;
    flush   = f;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(8'h00, 1'b0, 3'b000, 3'b000);
    tick();
    tick();
    checks++; if (a_acc !== 1'b0) begin errors++; $display("FAIL reset_accept: got %b exp 0", a_acc); end
    checks++; if (a_ctrl !== 24'h0) begin errors++; $display("FAIL reset_ctrl: got %h exp 000000", a_ctrl); end
    checks++; if (a_vld !== 3'b000) begin errors++; $display("FAIL reset_valid: got %b exp 000", a_vld); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", a_err); end
    checks++; if (a_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", a_cnt); end
    checks++; if (b_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt_b: got %0d exp 0", b_cnt); end
  endtask

  task automatic test_pipeline();
    reset = 1'b0;
    drive(8'h11, 1'b1, 3'b000, 3'b000);
    checks++; if (a_acc !== 1'b1) begin errors++; $display("FAIL pipe_accept: got %b exp 1", a_acc); end
    tick();
    checks++; if (a_ctrl !== 24'h000011) begin errors++; $display("FAIL pipe_lat1: got %h exp 000011", a_ctrl); end
    drive(8'h22, 1'b1, 3'b000, 3'b000);
    tick();
    drive(8'h33, 1'b1, 3'b000, 3'b000);
    tick();
    checks++; if (a_ctrl !== 24'h112233) begin errors++; $display("FAIL pipe_ctrl: got %h exp 112233", a_ctrl); end
    checks++; if (a_vld !== 3'b111) begin errors++; $display("FAIL pipe_valid: got %b exp 111", a_vld); end
    checks++; if (b_ctrl !== 24'h012233) begin errors++; $display("FAIL pipe_ctrl_mask: got %h exp 012233", b_ctrl); end
    checks++; if (a_cnt !== 16'd3) begin errors++; $display("FAIL pipe_bubbles: got %0d exp 3", a_cnt); end
    checks++; if ({c_ctrl, c_vld} !== {8'h33, 1'b1}) begin errors++; $display("FAIL pipe_one_stage: got %h/%b exp 33/1", c_ctrl, c_vld); end
  endtask

  task automatic test_stall();
    drive(8'hA5, 1'b1, 3'b000, 3'b000);
    tick();
    checks++; if (a_ctrl !== 24'h2233A5) begin errors++; $display("FAIL stall_pre: got %h exp 2233A5", a_ctrl); end
    drive(8'h5A, 1'b1, 3'b001, 3'b000);
    checks++; if (a_acc !== 1'b0) begin errors++; $display("FAIL stall_accept: got %b exp 0", a_acc); end
    tick();
    checks++; if ({a_ctrl, a_vld} !== {24'h3300A5, 3'b101}) begin errors++; $display("FAIL stall_c1: got %h/%b exp 3300A5/101", a_ctrl, a_vld); end
    tick();
    checks++; if ({a_ctrl, a_vld} !== {24'h0000A5, 3'b001}) begin errors++; $display("FAIL stall_c2: got %h/%b exp 0000A5/001", a_ctrl, a_vld); end
    drive(8'h5A, 1'b1, 3'b000, 3'b000);
    tick();
    checks++; if ({a_ctrl, a_vld} !== {24'h00A55A, 3'b011}) begin errors++; $display("FAIL stall_release: got %h/%b exp 00A55A/011", a_ctrl, a_vld); end
  endtask

  task automatic test_flush();
    drive(8'h00, 1'b0, 3'b000, 3'b000);
    tick();
    checks++; if ({a_ctrl, a_vld} !== {24'hA55A00, 3'b110}) begin errors++; $display("FAIL flush_pre: got %h/%b exp A55A00/110", a_ctrl, a_vld); end
    drive(8'h77, 1'b1, 3'b001, 3'b001);
    checks++; if (a_acc !== 1'b0) begin errors++; $display("FAIL flush_accept: got %b exp 0", a_acc); end
    tick();
    checks++; if ({a_ctrl, a_vld} !== {24'h5A0000, 3'b100}) begin errors++; $display("FAIL flush_over_stall: got %h/%b exp 5A0000/100", a_ctrl, a_vld); end
    drive(8'h77, 1'b1, 3'b000, 3'b000);
    tick();
    drive(8'h99, 1'b1, 3'b000, 3'b001);
    tick();
    checks++; if ({a_ctrl, a_vld} !== {24'h007700, 3'b010}) begin errors++; $display("FAIL flush_s0: got %h/%b exp 007700/010", a_ctrl, a_vld); end
  endtask

  task automatic test_mask();
    drive(8'hFF, 1'b1, 3'b000, 3'b000);
    tick();
    tick();
    drive(8'h00, 1'b0, 3'b000, 3'b000);
    tick();
    checks++; if ({b_ctrl, b_vld} !== {24'h0FFF00, 3'b110}) begin errors++; $display("FAIL mask_b: got %h/%b exp 0FFF00/110", b_ctrl, b_vld); end
    checks++; if (a_ctrl !== 24'hFFFF00) begin errors++; $display("FAIL mask_a: got %h exp FFFF00", a_ctrl); end
  endtask

  task automatic test_stall_err();
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL err_pre: got %b exp 0", a_err); end
    drive(8'h00, 1'b0, 3'b010, 3'b000);
    tick();
    checks++; if ({a_err, b_err} !== 2'b11) begin errors++; $display("FAIL err_set: got %b exp 11", {a_err, b_err}); end
    checks++; if (c_err !== 1'b0) begin errors++; $display("FAIL err_one_stage: got %b exp 0", c_err); end
    drive(8'h00, 1'b0, 3'b000, 3'b000);
    tick();
    tick();
    checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b exp 1", a_err); end
  endtask

  task automatic test_saturation();
    reset = 1'b1;
    tick();
    checks++; if ({a_err, a_cnt} !== {1'b0, 16'd0}) begin errors++; $display("FAIL sat_reset: got %b/%0d exp 0/0", a_err, a_cnt); end
    reset = 1'b0;
    drive(8'h00, 1'b0, 3'b000, 3'b000);
    for (int i = 0; i < 15; i++) tick();
    checks++; if (b_cnt !== 4'd15) begin errors++; $display("FAIL sat_reach: got %0d exp 15", b_cnt); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (b_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d exp 15", b_cnt); end
    checks++; if (a_cnt !== 16'd20) begin errors++; $display("FAIL sat_wide: got %0d exp 20", a_cnt); end
  endtask

  task automatic test_back_to_back_reset();
    drive(8'h12, 1'b1, 3'b000, 3'b000);
    tick();
    drive(8'h34, 1'b1, 3'b000, 3'b000);
    tick();
    drive(8'h56, 1'b1, 3'b000, 3'b000);
    tick();
    checks++; if ({a_ctrl, a_vld} !== {24'h123456, 3'b111}) begin errors++; $display("FAIL b2b_fill: got %h/%b exp 123456/111", a_ctrl, a_vld); end
    reset = 1'b1;
    #1;
    checks++; if (a_acc !== 1'b0) begin errors++; $display("FAIL b2b_accept: got %b exp 0", a_acc); end
    tick();
    checks++; if ({a_ctrl, a_vld, a_err, a_cnt} !== 44'h0) begin errors++; $display("FAIL b2b_reset_a: got %h/%b/%b/%0d exp all 0", a_ctrl, a_vld, a_err, a_cnt); end
    checks++; if ({b_ctrl, b_vld, b_cnt} !== 31'h0) begin errors++; $display("FAIL b2b_reset_b: got %h/%b/%0d exp all 0", b_ctrl, b_vld, b_cnt); end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pipeline();
    test_stall();
    test_flush();
    test_mask();
    test_stall_err();
    test_saturation();
    test_back_to_back_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_regs.md
Name: ctrl_pipe_regs

Overview:
- Parametrised, N-stage control-signal pipeline for the pipelined MIPS core.
- Carries one decoded control bundle (CW bits) from decode through stages 0..NSTAGES-1 (default E, M, W).
- Per-stage stall and flush, per-stage valid bit, per-stage bit pruning mask, stall-order error detection and a saturating bubble counter at the last stage.
- Replaces hand-written per-stage control registers with one generic block.

Parameters:
- NSTAGES, 3, number of pipeline registers (stage 0 = first register after decode); legal 1..8.
- CW, 8, control bundle width in bits; legal 1..32.
- KEEP_MASK, {NSTAGES*CW{1'b1}}, per-stage keep mask; slice k = bits [k*CW +: CW]; bits at 0 are forced to 0 whenever stage k loads.
- CNTW, 16, bubble counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ctrl_d  in  CW  control bundle from decoder.
- valid_d  in  1  ctrl_d holds a real instruction.
- stall  in  NSTAGES  stall[k]=1: register k holds its contents.
- flush  in  NSTAGES  flush[k]=1: register k becomes a bubble.
- accept_d  out  1  combinational: decode bundle is captured this edge; = ~stall[0] & ~flush[0] & ~reset.
- ctrl_q  out  NSTAGES*CW  registered bundle per stage, stage k at [k*CW +: CW].
- valid_q  out  NSTAGES  registered valid per stage.
- stall_err  out  1  sticky: illegal stall pattern seen.
- bubble_cnt  out  CNTW  saturating count of cycles with valid_q[NSTAGES-1]=0.

Behaviour:
- Reset (synchronous, active-high): all ctrl_q=0, valid_q=0, stall_err=0, bubble_cnt=0. Reset has priority over every other input. Reset mid-stream discards all in-flight bundles. No X on any output after the first reset edge.
- Source of stage k: ctrl_d/valid_d for k=0; register k-1 for k>0.
- Per-register next-state, in priority order:
  - flush[k]=1: ctrl_q[k] <= 0, valid_q[k] <= 0. Flush overrides stall.
  - stall[k]=1: hold.
  - k>0 and stall[k-1]=1 and flush[k-1]=0: load bubble (0, valid 0). A held upstream entry is never duplicated.
  - otherwise: ctrl_q[k] <= source & KEEP_MASK slice k; valid_q[k] <= source valid.
- valid_d=0 with ctrl_d≠0 is accepted as-is; downstream logic must gate on valid_q.
- Latency: a bundle accepted at edge n appears in stage k after edge n+k, with no stalls.
- Stall ordering:
  - Legal patterns are monotone: stall[k]=1 requires stall[j]=1 for all j<k.
  - Any cycle (reset=0) with stall[k]=1 and stall[k-1]=0 for some k≥1 sets stall_err=1 at that edge.
  - stall_err stays set until reset.
  - Datapath still follows the priority rules above; the upstream entry entering stage k is lost.
- Bubble counter:
  - Increments at each non-reset edge where the pre-edge valid_q[NSTAGES-1]=0.
  - Saturates at 2^CNTW-1 with no wrap.
  - Reset-released first edge counts, since valid_q=0 after reset.
- NSTAGES=1: only stage 0; the stall-order check is inactive and stall_err stays 0.
- No combinational path from stall/flush to ctrl_q/valid_q. accept_d is the only combinational output.

Test Plan:
- Reset, then feed valid bundles 0x11,0x22,0x33 on consecutive cycles with no stalls -> after edge 3: stage0=0x33, stage1=0x22, stage2=0x11, valid_q=3'b111.
- stall=3'b001 for 2 cycles with 0xA5 in stage 0 and 0x5A input -> stage0 holds 0xA5, stage1 bubble (0, valid 0), accept_d=0. After release, 0x5A enters.
- flush=3'b001 with stall=3'b001 in the same cycle -> stage0 becomes 0/valid 0 (flush wins), stage1 receives bubble.
- KEEP_MASK slice2=8'h0F, bundle 0xFF -> stage1=0xFF, stage2=0x0F.
- stall=3'b010 (non-monotone) -> stall_err=1 next edge and stays 1 after stall returns to 0, until reset.
- CNTW=4, hold valid_d=0 for 20 cycles -> bubble_cnt stops at 15. Assert reset mid-run -> all outputs 0 on the following edge.
